// File: rtl/globefish_qspi_pkg.sv
// Shared constants, state encoding and helpers for the globefish QSPI XIP subsystem.
package globefish_qspi_pkg;

  localparam logic [7:0] CMD_QPI_EN = 8'h35;
  localparam logic [7:0] CMD_QREAD  = 8'hEB;
  localparam logic [7:0] CMD_QWRITE = 8'h38;

  localparam logic [3:0] DUMMY_ROM = 4'd8;
  localparam logic [3:0] DUMMY_RAM = 4'd6;

  localparam logic [3:0] SCK_CMD_SERIAL = 4'd8;
  localparam logic [3:0] SCK_CMD_QUAD   = 4'd2;
  localparam logic [3:0] SCK_ADDR       = 4'd6;
  localparam logic [3:0] SCK_DATA       = 4'd8;

  localparam logic [3:0] OEN_SERIAL = 4'b0001;
  localparam logic [3:0] OEN_QUAD   = 4'b1111;
  localparam logic [3:0] OEN_NONE   = 4'b0000;

  typedef enum logic [2:0] {
    INIT_CS,
    INIT_CMD,
    IDLE,
    CMD,
    ADDR,
    DUMMY,
    DATA,
    END
  } state_e;

  // Word address to 24-bit device byte address.
  function automatic logic [23:0] mem_addr(input logic [21:0] word_addr);
    return {word_addr, 2'b00};
  endfunction

endpackage

// File: rtl/globefish_qspi_shift.sv
// SCK generator, MSB-first serial/quad shifter, receive shifter and per-phase SCK counter.
module globefish_qspi_shift
  import globefish_qspi_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_in,
  input  logic        load_i,
  input  logic        quad_i,
  input  logic [3:0]  sck_cnt_i,
  input  logic [3:0]  oen_i,
  input  logic [31:0] data_i,
  input  logic [3:0]  sd_i,
  output logic        sck_o,
  output logic [3:0]  sd_o,
  output logic [3:0]  oen_o,
  output logic [31:0] rx_o,
  output logic        last_o,
  output logic        done_o
);

  logic        sck_reg, sck_next;
  logic [3:0]  cnt_reg, cnt_next;
  logic [31:0] sh_reg, sh_next;
  logic        quad_reg, quad_next;
  logic [3:0]  oen_reg, oen_next;
  logic [31:0] rx_reg, rx_next;

  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      sck_reg  <= 1'b0;
      cnt_reg  <= 4'd0;
      sh_reg   <= 32'd0;
      quad_reg <= 1'b0;
      oen_reg  <= OEN_NONE;
      rx_reg   <= 32'd0;
    end else begin
      sck_reg  <= sck_next;
      cnt_reg  <= cnt_next;
      sh_reg   <= sh_next;
      quad_reg <= quad_next;
      oen_reg  <= oen_next;
      rx_reg   <= rx_next;
    end
  end

  // A load always lands on a falling SCK half so the new phase's first
  // nibble is set up while SCK is low.
  always_comb begin
    sck_next  = sck_reg;
    cnt_next  = cnt_reg;
    sh_next   = sh_reg;
    quad_next = quad_reg;
    oen_next  = oen_reg;
    rx_next   = rx_reg;
    if (load_i) begin
      sck_next  = 1'b0;
      cnt_next  = sck_cnt_i;
      sh_next   = data_i;
      quad_next = quad_i;
      oen_next  = oen_i;
    end else if (cnt_reg != 4'd0) begin
      if (!sck_reg) begin
        sck_next = 1'b1;
      end else begin
        sck_next = 1'b0;
        cnt_next = cnt_reg - 4'd1;
        sh_next  = quad_reg ? {sh_reg[27:0], 4'b0000} : {sh_reg[30:0], 1'b0};
      end
    end else begin
      oen_next = OEN_NONE;
    end
    // Pads are sampled at the end of every SCK-high cycle, independent of loads.
    if (cnt_reg != 4'd0 && sck_reg) begin
      rx_next = {rx_reg[27:0], sd_i};
    end
  end

  genvar gi;
  for (gi = 0; gi < 4; gi++) begin : g_sd
    if (gi == 0) begin : g_lane0
      assign sd_o[gi] = quad_reg ? sh_reg[28] : sh_reg[31];
    end else begin : g_lane
      assign sd_o[gi] = quad_reg & sh_reg[28 + gi];
    end
  end

  assign sck_o  = sck_reg;
  assign oen_o  = oen_reg;
  assign rx_o   = rx_reg;
  assign last_o = sck_reg && (cnt_reg == 4'd1);
  assign done_o = (cnt_reg == 4'd0);

endmodule

// File: rtl/globefish_soc_qspi.sv
// QSPI XIP controller: turns 32-bit word requests into ROM/PSRAM QSPI transactions.
module globefish_soc_qspi
  import globefish_qspi_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_in,
  input  logic        en_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [24:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        ack_o,
  output logic        busy_o,
  output logic        qspi_mem_cs_rom_on,
  output logic        qspi_mem_cs_ram_on,
  output logic        qspi_mem_sck_o,
  output logic [3:0]  qspi_mem_sd_o,
  output logic [3:0]  qspi_mem_oen_o,
  input  logic [3:0]  qspi_mem_sd_i
);

  state_e      state_reg, state_next;
  logic        we_reg, we_next;
  logic        ram_reg, ram_next;
  logic [21:0] waddr_reg, waddr_next;
  logic [31:0] wdata_reg, wdata_next;
  logic [31:0] rdata_reg, rdata_next;

  logic        ld;
  logic        ld_quad;
  logic [3:0]  ld_sck;
  logic [3:0]  ld_oen;
  logic [31:0] ld_data;
  logic        sh_last;
  logic        sh_done;
  logic [31:0] rx_data;
  logic [31:0] tx_word;
  logic [31:0] rx_word;
  logic        accept;
  logic        xfer;
  logic        unused_addr_bits;

  assign unused_addr_bits = ^addr_i[1:0];

  // Bus words are little-endian on the wire: byte 0 travels first.
  genvar gi;
  for (gi = 0; gi < 4; gi++) begin : g_swap
    assign tx_word[31 - 8*gi -: 8] = wdata_reg[8*gi +: 8];
    assign rx_word[8*gi +: 8]      = rx_data[31 - 8*gi -: 8];
  end

  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      state_reg <= INIT_CS;
      we_reg    <= 1'b0;
      ram_reg   <= 1'b0;
      waddr_reg <= 22'd0;
      wdata_reg <= 32'd0;
      rdata_reg <= 32'd0;
    end else begin
      state_reg <= state_next;
      we_reg    <= we_next;
      ram_reg   <= ram_next;
      waddr_reg <= waddr_next;
      wdata_reg <= wdata_next;
      rdata_reg <= rdata_next;
    end
  end

  assign accept = (state_reg == IDLE) && req_i && en_i;

  always_comb begin
    state_next = state_reg;
    we_next    = we_reg;
    ram_next   = ram_reg;
    waddr_next = waddr_reg;
    wdata_next = wdata_reg;
    rdata_next = rdata_reg;
    ld         = 1'b0;
    ld_quad    = 1'b1;
    ld_sck     = 4'd0;
    ld_oen     = OEN_NONE;
    ld_data    = 32'd0;
    case (state_reg)
      INIT_CS: begin
        ld         = 1'b1;
        ld_quad    = 1'b0;
        ld_sck     = SCK_CMD_SERIAL;
        ld_oen     = OEN_SERIAL;
        ld_data    = {CMD_QPI_EN, 24'h000000};
        state_next = INIT_CMD;
      end
      INIT_CMD: begin
        if (sh_done) state_next = IDLE;
      end
      IDLE: begin
        if (accept) begin
          we_next    = we_i;
          ram_next   = addr_i[24];
          waddr_next = addr_i[23:2];
          wdata_next = wdata_i;
          // The ROM is read-only: a write is acknowledged without touching the bus.
          if (we_i && !addr_i[24]) begin
            state_next = END;
          end else begin
            state_next = CMD;
            ld         = 1'b1;
            ld_data    = {(we_i ? CMD_QWRITE : CMD_QREAD), 24'h000000};
            ld_quad    = addr_i[24];
            ld_sck     = addr_i[24] ? SCK_CMD_QUAD : SCK_CMD_SERIAL;
            ld_oen     = addr_i[24] ? OEN_QUAD : OEN_SERIAL;
          end
        end
      end
      CMD: begin
        if (sh_last) begin
          state_next = ADDR;
          ld         = 1'b1;
          ld_sck     = SCK_ADDR;
          ld_oen     = OEN_QUAD;
          ld_data    = {mem_addr(waddr_reg), 8'h00};
        end
      end
      ADDR: begin
        if (sh_last) begin
          ld = 1'b1;
          if (we_reg) begin
            state_next = DATA;
            ld_sck     = SCK_DATA;
            ld_oen     = OEN_QUAD;
            ld_data    = tx_word;
          end else begin
            state_next = DUMMY;
            ld_sck     = ram_reg ? DUMMY_RAM : DUMMY_ROM;
            ld_oen     = OEN_NONE;
          end
        end
      end
      DUMMY: begin
        if (sh_last) begin
          state_next = DATA;
          ld         = 1'b1;
          ld_sck     = SCK_DATA;
          ld_oen     = OEN_NONE;
        end
      end
      DATA: begin
        if (sh_done) begin
          state_next = END;
          if (!we_reg) rdata_next = rx_word;
        end
      end
      END: begin
        state_next = IDLE;
      end
      default: begin
        state_next = INIT_CS;
      end
    endcase
  end

  globefish_qspi_shift u_shift (
    .clk_i     (clk_i),
    .rst_in    (rst_in),
    .load_i    (ld),
    .quad_i    (ld_quad),
    .sck_cnt_i (ld_sck),
    .oen_i     (ld_oen),
    .data_i    (ld_data),
    .sd_i      (qspi_mem_sd_i),
    .sck_o     (qspi_mem_sck_o),
    .sd_o      (qspi_mem_sd_o),
    .oen_o     (qspi_mem_oen_o),
    .rx_o      (rx_data),
    .last_o    (sh_last),
    .done_o    (sh_done)
  );

  assign xfer = (state_reg == CMD) || (state_reg == ADDR) ||
                (state_reg == DUMMY) || (state_reg == DATA);

  assign qspi_mem_cs_rom_on = !(xfer && !ram_reg);
  assign qspi_mem_cs_ram_on = !((state_reg == INIT_CMD) || (xfer && ram_reg));
  assign ack_o              = (state_reg == END);
  assign busy_o             = (state_reg != IDLE);
  assign rdata_o            = rdata_reg;

endmodule

// File: tb/tb_globefish_soc_qspi.sv
// Directed bench for globefish_soc_qspi with a small ROM/PSRAM pad model.
module tb_globefish_soc_qspi;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [24:0] addr = 25'd0;
  logic [31:0] wdata = 32'd0;
  logic [31:0] rdata;
  logic        ack;
  logic        busy;
  logic        cs_rom_n;
  logic        cs_ram_n;
  logic        sck;
  logic [3:0]  sd_out;
  logic [3:0]  oen;
  logic [3:0]  sd_in = 4'h0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  globefish_soc_qspi dut (
    .clk_i              (clk),
    .rst_in             (rst_n),
    .en_i               (en),
    .req_i              (req),
    .we_i               (we),
    .addr_i             (addr),
    .wdata_i            (wdata),
    .rdata_o            (rdata),
    .ack_o              (ack),
    .busy_o             (busy),
    .qspi_mem_cs_rom_on (cs_rom_n),
    .qspi_mem_cs_ram_on (cs_ram_n),
    .qspi_mem_sck_o     (sck),
    .qspi_mem_sd_o      (sd_out),
    .qspi_mem_oen_o     (oen),
    .qspi_mem_sd_i      (sd_in)
  );

  // ---------------- pad model: captures each SCK and answers reads ----------
  logic [3:0]  cap_sd  [0:31];
  logic [3:0]  cap_oen [0:31];
  int          sck_cnt = 0;
  logic        prev_sck = 1'b0;
  logic        prev_rom_n = 1'b1;
  logic        prev_ram_n = 1'b1;
  logic [31:0] ram_mem [logic [23:0]];

  function automatic logic [31:0] rom_word(input logic [23:0] a);
    return (a == 24'h000100) ? 32'h12345678 : {8'hA5, a};
  endfunction

  function automatic logic [23:0] cap_addr(input int base);
    logic [23:0] a = 24'd0;
    for (int i = 0; i < 6; i++) a = {a[19:0], cap_sd[base + i]};
    return a;
  endfunction

  function automatic logic [31:0] nib_seq(input int base, input int n);
    logic [31:0] v = 32'd0;
    for (int i = 0; i < n; i++) v = {v[27:0], cap_sd[base + i]};
    return v;
  endfunction

  function automatic logic [7:0] ser_byte(input int base);
    logic [7:0] b = 8'd0;
    for (int i = 0; i < 8; i++) b = {b[6:0], cap_sd[base + i][0]};
    return b;
  endfunction

  function automatic logic oen_all(input int base, input int n, input logic [3:0] v);
    logic ok = 1'b1;
    for (int i = 0; i < n; i++) if (cap_oen[base + i] !== v) ok = 1'b0;
    return ok;
  endfunction

  function automatic logic [3:0] word_nib(input logic [31:0] w, input int idx);
    logic [31:0] s;
    s = w >> (8 * (idx / 2));
    return (idx % 2 == 0) ? s[7:4] : s[3:0];
  endfunction

  always @(negedge clk) begin
    logic [31:0] seq;
    if ((!cs_rom_n || !cs_ram_n) && prev_rom_n && prev_ram_n) begin
      sck_cnt  = 0;
      prev_sck = 1'b0;
    end
    if (!cs_rom_n || !cs_ram_n) begin
      if (sck && !prev_sck && sck_cnt < 32) begin
        cap_sd[sck_cnt]  = sd_out;
        cap_oen[sck_cnt] = oen;
        sck_cnt++;
      end
      prev_sck = sck;
    end
    if (cs_ram_n && !prev_ram_n && sck_cnt == 16 && cap_sd[0] == 4'h3 && cap_sd[1] == 4'h8) begin
      seq = nib_seq(8, 8);
      ram_mem[cap_addr(2)] = {seq[7:0], seq[15:8], seq[23:16], seq[31:24]};
    end
    prev_rom_n = cs_rom_n;
    prev_ram_n = cs_ram_n;
    if (!sck) begin
      sd_in = 4'h0;
      if (!cs_rom_n && sck_cnt >= 22 && sck_cnt < 30)
        sd_in = word_nib(rom_word(cap_addr(8)), sck_cnt - 22);
      else if (!cs_ram_n && cap_sd[0] == 4'hE && cap_sd[1] == 4'hB && sck_cnt >= 14 && sck_cnt < 22)
        sd_in = word_nib(ram_mem.exists(cap_addr(2)) ? ram_mem[cap_addr(2)] : 32'd0, sck_cnt - 14);
    end
  end

  // ---------------- helpers -------------------------------------------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_init(input string tag);
    int ram_low = 0;
    int rom_low = 0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (!cs_ram_n) ram_low++;
      if (!cs_rom_n) rom_low++;
      if (k == 1)  chk({tag, "_cs_ram_fall"}, {31'd0, cs_ram_n}, 32'd0);
      if (k == 17) chk({tag, "_busy_c17"}, {31'd0, busy}, 32'd1);
      if (k == 18) chk({tag, "_busy_c18"}, {31'd0, busy}, 32'd0);
    end
    chk({tag, "_ram_low_cycles"}, ram_low, 32'd17);
    chk({tag, "_rom_low_cycles"}, rom_low, 32'd0);
    chk({tag, "_sck_count"}, sck_cnt, 32'd8);
    chk({tag, "_cmd_byte"}, {24'd0, ser_byte(0)}, 32'h35);
    chk({tag, "_oen"}, {31'd0, oen_all(0, 8, 4'b0001)}, 32'd1);
    $display("txn init %s ram_low=%0d sck=%0d", tag, ram_low, sck_cnt);
  endtask

  task automatic do_txn(input logic w, input logic [24:0] a, input logic [31:0] d,
                        output int lat, output logic [31:0] rd,
                        output logic [1:0] cs1, output int cslow);
    @(negedge clk);
    req = 1'b1; en = 1'b1; we = w; addr = a; wdata = d;
    lat = -1; cslow = 0; cs1 = 2'b00; rd = 32'd0;
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      if (n == 1) cs1 = {cs_rom_n, cs_ram_n};
      if (!cs_rom_n || !cs_ram_n) cslow++;
      if (ack) begin
        lat = n;
        rd = rdata;
        break;
      end
    end
    req = 1'b0;
    $display("txn we=%0d addr=%07h wdata=%08h lat=%0d rdata=%08h", w, a, d, lat, rd);
  endtask

  // ---------------- directed sequence ---------------------------------------
  initial begin
    int          lat;
    int          cslow;
    int          viol;
    logic [31:0] rd;
    logic [1:0]  cs1;

    repeat (3) @(negedge clk);
    chk("rst_cs_rom", {31'd0, cs_rom_n}, 32'd1);
    chk("rst_cs_ram", {31'd0, cs_ram_n}, 32'd1);
    chk("rst_sck", {31'd0, sck}, 32'd0);
    chk("rst_sd", {28'd0, sd_out}, 32'd0);
    chk("rst_oen", {28'd0, oen}, 32'd0);
    chk("rst_ack", {31'd0, ack}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd1);
    chk("rst_rdata", rdata, 32'd0);

    check_init("init");

    // ROM read at 0x000100
    do_txn(1'b0, 25'h0000100, 32'd0, lat, rd, cs1, cslow);
    chk("rom_rd_lat", lat, 32'd62);
    chk("rom_rd_data", rd, 32'h12345678);
    chk("rom_rd_cs1", {30'd0, cs1}, 32'b01);
    chk("rom_rd_cslow", cslow, 32'd61);
    chk("rom_rd_sck", sck_cnt, 32'd30);
    chk("rom_rd_cmd", {24'd0, ser_byte(0)}, 32'hEB);
    chk("rom_rd_addr", nib_seq(8, 6), 32'h000100);
    chk("rom_rd_oen_addr", {31'd0, oen_all(8, 6, 4'b1111)}, 32'd1);
    chk("rom_rd_oen_dummy", {31'd0, oen_all(14, 16, 4'b0000)}, 32'd1);

    // RAM write 0xDEADBEEF at 0x1000010
    do_txn(1'b1, 25'h1000010, 32'hDEADBEEF, lat, rd, cs1, cslow);
    chk("ram_wr_lat", lat, 32'd34);
    chk("ram_wr_cs1", {30'd0, cs1}, 32'b10);
    chk("ram_wr_cslow", cslow, 32'd33);
    chk("ram_wr_sck", sck_cnt, 32'd16);
    chk("ram_wr_cmd", nib_seq(0, 2), 32'h38);
    chk("ram_wr_addr", nib_seq(2, 6), 32'h000010);
    chk("ram_wr_data", nib_seq(8, 8), 32'hEFBEADDE);
    chk("ram_wr_oen", {31'd0, oen_all(0, 16, 4'b1111)}, 32'd1);

    // RAM read back
    do_txn(1'b0, 25'h1000010, 32'd0, lat, rd, cs1, cslow);
    chk("ram_rd_lat", lat, 32'd46);
    chk("ram_rd_data", rd, 32'hDEADBEEF);
    chk("ram_rd_cs1", {30'd0, cs1}, 32'b10);
    chk("ram_rd_sck", sck_cnt, 32'd22);
    chk("ram_rd_cmd", nib_seq(0, 2), 32'hEB);
    chk("ram_rd_addr", nib_seq(2, 6), 32'h000010);
    chk("ram_rd_oen_cmdaddr", {31'd0, oen_all(0, 8, 4'b1111)}, 32'd1);
    chk("ram_rd_oen_wait_data", {31'd0, oen_all(8, 14, 4'b0000)}, 32'd1);

    // Write to ROM: no bus activity, immediate ack, rdata held
    do_txn(1'b1, 25'h0000040, 32'h01020304, lat, rd, cs1, cslow);
    chk("rom_wr_lat", lat, 32'd1);
    chk("rom_wr_cslow", cslow, 32'd0);
    chk("rom_wr_rdata_hold", rd, 32'hDEADBEEF);

    // en_i low blocks acceptance
    @(negedge clk);
    en = 1'b0; req = 1'b1; we = 1'b0; addr = 25'h0000200;
    viol = 0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (!cs_rom_n || !cs_ram_n || ack) viol++;
    end
    chk("en_low_idle", viol, 32'd0);
    do_txn(1'b0, 25'h0000200, 32'd0, lat, rd, cs1, cslow);
    chk("en_rise_cs1", {30'd0, cs1}, 32'b01);
    chk("en_rise_lat", lat, 32'd62);
    chk("en_rise_data", rd, 32'hA5000200);

    // Reset in the middle of a ROM read
    @(negedge clk);
    req = 1'b1; en = 1'b1; we = 1'b0; addr = 25'h0000100;
    viol = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (ack) viol++;
    end
    chk("mid_cs_before", {31'd0, cs_rom_n}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("mid_cs_rom", {31'd0, cs_rom_n}, 32'd1);
    chk("mid_sck", {31'd0, sck}, 32'd0);
    chk("mid_oen", {28'd0, oen}, 32'd0);
    chk("mid_busy", {31'd0, busy}, 32'd1);
    chk("mid_rdata", rdata, 32'd0);
    req = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (ack) viol++;
    end
    chk("mid_no_ack", viol, 32'd0);
    check_init("reinit");

    do_txn(1'b0, 25'h0000100, 32'd0, lat, rd, cs1, cslow);
    chk("post_rst_lat", lat, 32'd62);
    chk("post_rst_data", rd, 32'h12345678);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
